// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared widths, port indices and arbiter defaults for the CPU memory path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int CELL_BITS        = 32;
    localparam int ADDR_BITS        = 11;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        PORT_LD   = 2'd0,
        PORT_DT   = 2'd1,
        PORT_IF   = 2'd2,
        PORT_NONE = 2'd3
    } port_e;

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// Module   : mem_arb_pick
// Brief    : Combinational winner selection: loader lock, fetch promotion, ld > dt > if.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_pick
    import cpu_pkg::*;
(
    input  logic  ld_req,
    input  logic  dt_req,
    input  logic  if_req,
    input  logic  ld_lock,
    input  logic  promote,
    output port_e sel
);

    always_comb begin
        sel = PORT_NONE;
        if (ld_lock) begin
            // The loader owns the RAM outright; everyone else waits.
            sel = ld_req ? PORT_LD : PORT_NONE;
        end else if (promote && if_req) begin
            sel = PORT_IF;
        end else if (ld_req) begin
            sel = PORT_LD;
        end else if (dt_req) begin
            sel = PORT_DT;
        end else if (if_req) begin
            sel = PORT_IF;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Three-port single-RAM arbiter with fetch starvation promotion.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int CELL_BITS    = cpu_pkg::CELL_BITS,
    parameter int ADDR_BITS    = cpu_pkg::ADDR_BITS,
    parameter int STARVE_LIMIT = cpu_pkg::STARVE_LIMIT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld_req,
    input  logic                 ld_we,
    input  logic [ADDR_BITS-1:0] ld_addr,
    input  logic [CELL_BITS-1:0] ld_wdata,
    output logic                 ld_gnt,
    output logic                 ld_rvalid,
    input  logic                 dt_req,
    input  logic                 dt_we,
    input  logic [ADDR_BITS-1:0] dt_addr,
    input  logic [CELL_BITS-1:0] dt_wdata,
    output logic                 dt_gnt,
    output logic                 dt_rvalid,
    input  logic                 if_req,
    input  logic                 if_we,
    input  logic [ADDR_BITS-1:0] if_addr,
    input  logic [CELL_BITS-1:0] if_wdata,
    output logic                 if_gnt,
    output logic                 if_rvalid,
    output logic [CELL_BITS-1:0] rdata,
    input  logic                 ld_lock,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [CELL_BITS-1:0] mem_wdata,
    input  logic [CELL_BITS-1:0] mem_rdata
);

    import cpu_pkg::*;

    localparam int c_cnt_w = $clog2(STARVE_LIMIT + 1);

    logic [c_cnt_w-1:0] r_starve_cnt;
    port_e              r_rv_owner;
    port_e              w_sel;
    port_e              w_gsel;
    logic               w_promote;

    assign w_promote = (r_starve_cnt == c_cnt_w'(STARVE_LIMIT));

    mem_arb_pick u_pick (
        .ld_req  (ld_req),
        .dt_req  (dt_req),
        .if_req  (if_req),
        .ld_lock (ld_lock),
        .promote (w_promote),
        .sel     (w_sel)
    );

    assign w_gsel = rst ? PORT_NONE : w_sel;

    assign ld_gnt = (w_gsel == PORT_LD);
    assign dt_gnt = (w_gsel == PORT_DT);
    assign if_gnt = (w_gsel == PORT_IF);
    assign mem_en = (w_gsel != PORT_NONE);

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (w_gsel)
            PORT_LD: begin
                mem_we    = ld_we;
                mem_addr  = ld_addr;
                mem_wdata = ld_wdata;
            end
            PORT_DT: begin
                mem_we    = dt_we;
                mem_addr  = dt_addr;
                mem_wdata = dt_wdata;
            end
            PORT_IF: begin
                mem_we    = if_we;
                mem_addr  = if_addr;
                mem_wdata = if_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_rv_owner   <= PORT_NONE;
        end else begin
            // Counter is frozen under the loader lock so promotion resumes where it left off.
            if (!ld_lock) begin
                if (!if_req || if_gnt) begin
                    r_starve_cnt <= '0;
                end else if (!w_promote) begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end
            r_rv_owner <= (mem_en && !mem_we) ? w_gsel : PORT_NONE;
        end
    end

    // Gating with rst squashes a read that was granted just before reset.
    assign ld_rvalid = !rst && (r_rv_owner == PORT_LD);
    assign dt_rvalid = !rst && (r_rv_owner == PORT_DT);
    assign if_rvalid = !rst && (r_rv_owner == PORT_IF);
    assign rdata     = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed scenarios plus randomized traffic against a rule-level arbiter model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int c_cw    = 32;
    localparam int c_aw    = 11;
    localparam int c_limit = 4;
    localparam int c_words = 2048;
    localparam int c_none  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            ld_lock;
    logic            req   [3];
    logic            we    [3];
    logic [c_aw-1:0] addr  [3];
    logic [c_cw-1:0] wdata [3];
    logic            ld_gnt, dt_gnt, if_gnt;
    logic            ld_rvalid, dt_rvalid, if_rvalid;
    logic [c_cw-1:0] rdata;
    logic            mem_en, mem_we;
    logic [c_aw-1:0] mem_addr;
    logic [c_cw-1:0] mem_wdata;
    logic [c_cw-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(
        .CELL_BITS    (c_cw),
        .ADDR_BITS    (c_aw),
        .STARVE_LIMIT (c_limit)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_req    (req[0]),
        .ld_we     (we[0]),
        .ld_addr   (addr[0]),
        .ld_wdata  (wdata[0]),
        .ld_gnt    (ld_gnt),
        .ld_rvalid (ld_rvalid),
        .dt_req    (req[1]),
        .dt_we     (we[1]),
        .dt_addr   (addr[1]),
        .dt_wdata  (wdata[1]),
        .dt_gnt    (dt_gnt),
        .dt_rvalid (dt_rvalid),
        .if_req    (req[2]),
        .if_we     (we[2]),
        .if_addr   (addr[2]),
        .if_wdata  (wdata[2]),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .rdata     (rdata),
        .ld_lock   (ld_lock),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Bench-owned single-port RAM, preloaded with an address hash on the first edge.
    logic            ram_load;
    logic [c_cw-1:0] ram [c_words];

    function automatic logic [c_cw-1:0] pattern(int a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < c_words; i++) ram[i] <= pattern(i);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Reference model state.
    logic [c_cw-1:0] shadow [c_words];
    int              m_starve;
    int              m_rv;
    logic [c_cw-1:0] m_rv_data;

    int              n_cmp;
    int              n_bad;
    logic [2:0]      obs_gnt;
    logic [2:0]      obs_rv;
    logic [c_cw-1:0] obs_rdata;
    int              obs_starve;
    logic            obs_en;

    task automatic check_eq(string tag, logic [c_cw-1:0] obs, logic [c_cw-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_pick();
        if (rst) return c_none;
        if (ld_lock) return req[0] ? 0 : c_none;
        if (req[2] && m_starve >= c_limit) return 2;
        for (int p = 0; p < 3; p++) if (req[p]) return p;
        return c_none;
    endfunction

    // One clock: check at the falling edge, advance the model, then retire the granted request.
    task automatic cycle();
        int         sel;
        logic [2:0] exp_rv;
        @(negedge clk);
        sel        = m_pick();
        obs_gnt    = {if_gnt, dt_gnt, ld_gnt};
        obs_rv     = {if_rvalid, dt_rvalid, ld_rvalid};
        obs_rdata  = rdata;
        obs_starve = int'(dut.r_starve_cnt);
        obs_en     = mem_en;
        check_eq("gnt", {29'd0, obs_gnt}, (sel == c_none) ? 32'd0 : (32'd1 << sel));
        check_eq("mem_en", {31'd0, mem_en}, {31'd0, sel != c_none});
        if (sel != c_none) begin
            check_eq("mem_we", {31'd0, mem_we}, {31'd0, we[sel]});
            check_eq("mem_addr", {21'd0, mem_addr}, {21'd0, addr[sel]});
            if (we[sel]) check_eq("mem_wdata", mem_wdata, wdata[sel]);
        end else begin
            check_eq("mem_we_idle", {31'd0, mem_we}, 32'd0);
        end
        exp_rv = (!rst && m_rv != c_none) ? (3'b001 << m_rv) : 3'b000;
        check_eq("rvalid", {29'd0, obs_rv}, {29'd0, exp_rv});
        if (exp_rv != 3'b000) check_eq("rdata", rdata, m_rv_data);
        check_eq("starve_cnt", obs_starve, m_starve);

        m_rv = c_none;
        if (sel != c_none) begin
            if (we[sel]) begin
                shadow[addr[sel]] = wdata[sel];
            end else begin
                m_rv      = sel;
                m_rv_data = shadow[addr[sel]];
            end
        end
        if (rst)                       m_starve = 0;
        else if (ld_lock)              m_starve = m_starve;
        else if (req[2] && sel != 2)   m_starve = (m_starve < c_limit) ? m_starve + 1 : c_limit;
        else                           m_starve = 0;

        @(posedge clk);
        #1;
        if (sel != c_none) req[sel] = 1'b0;
    endtask

    task automatic set_req(int p, logic w, int a, logic [c_cw-1:0] d);
        req[p]   = 1'b1;
        we[p]    = w;
        addr[p]  = c_aw'(a);
        wdata[p] = d;
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (!(req[0] || req[1] || req[2])) break;
            cycle();
        end
        check_eq("drain_done", {31'd0, req[0] || req[1] || req[2]}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_if;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        ld_lock = 1'b0;
        ram_load = 1'b1;
        for (int p = 0; p < 3; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
        end
        for (int i = 0; i < c_words; i++) shadow[i] = pattern(i);
        m_starve = 0;
        m_rv = c_none;
        m_rv_data = '0;
        @(posedge clk);
        #1;
        ram_load = 1'b0;

        // Requests during reset must not be granted.
        set_req(0, 1'b0, 1, 0);
        set_req(2, 1'b0, 2, 0);
        cycle();
        check_eq("rst_idle_gnt", {29'd0, obs_gnt}, 32'd0);
        req[0] = 1'b0; req[2] = 1'b0;
        rst = 1'b0;
        cycle();
        check_eq("post_rst_rv", {29'd0, obs_rv}, 32'd0);

        // Simultaneous reads resolve ld, dt, if in order.
        set_req(0, 1'b0, 'h010, 0);
        set_req(1, 1'b0, 'h020, 0);
        set_req(2, 1'b0, 'h030, 0);
        cycle();
        check_eq("s29_g1", {29'd0, obs_gnt}, 32'b001);
        cycle();
        check_eq("s29_g2", {29'd0, obs_gnt}, 32'b010);
        check_eq("s29_rv_ld", {29'd0, obs_rv}, 32'b001);
        check_eq("s29_d_ld", obs_rdata, shadow['h010]);
        cycle();
        check_eq("s29_g3", {29'd0, obs_gnt}, 32'b100);
        check_eq("s29_d_dt", obs_rdata, shadow['h020]);
        cycle();
        check_eq("s29_rv_if", {29'd0, obs_rv}, 32'b100);
        check_eq("s29_d_if", obs_rdata, shadow['h030]);

        // Fetch starved by a dt stream gets promoted on its fifth cycle.
        first_if = 0;
        set_req(2, 1'b0, 'h005, 0);
        for (int i = 1; i <= 8; i++) begin
            if (!req[1]) set_req(1, 1'b0, $urandom_range(0, 2047), 0);
            cycle();
            if (obs_gnt[2] && first_if == 0) first_if = i;
            if (first_if != 0 && i == first_if + 1)
                check_eq("s30_dt_resume", {29'd0, obs_gnt}, 32'b010);
        end
        check_eq("s30_first_if", first_if, 5);
        drain();

        // Loader lock: exclusive ld, frozen counter, data visible after release.
        set_req(1, 1'b0, 'h100, 0);
        set_req(2, 1'b0, 'h005, 0);
        cycle();
        ld_lock = 1'b1;
        set_req(0, 1'b1, 'h7FF, 32'hDEAD_BEEF);
        set_req(1, 1'b0, 'h7FF, 0);
        cycle();
        check_eq("s31_lock_g", {29'd0, obs_gnt}, 32'b001);
        cycle();
        check_eq("s31_lock_idle", {29'd0, obs_gnt}, 32'b000);
        check_eq("s31_frozen", obs_starve, 1);
        ld_lock = 1'b0;
        cycle();
        check_eq("s31_rel_g", {29'd0, obs_gnt}, 32'b010);
        check_eq("s31_frozen2", obs_starve, 1);
        cycle();
        check_eq("s31_rd_rv", {29'd0, obs_rv}, 32'b010);
        check_eq("s31_rd_data", obs_rdata, 32'hDEAD_BEEF);
        drain();
        cycle();

        // Read-after-write through RAM order; the write itself returns nothing.
        set_req(1, 1'b1, 'h040, 32'h1234_5678);
        cycle();
        check_eq("s32_wr_g", {29'd0, obs_gnt}, 32'b010);
        set_req(2, 1'b0, 'h040, 0);
        cycle();
        check_eq("s32_no_rv", {29'd0, obs_rv}, 32'b000);
        cycle();
        check_eq("s32_rv", {29'd0, obs_rv}, 32'b100);
        check_eq("s32_data", obs_rdata, 32'h1234_5678);

        // A read squashed by reset.
        set_req(1, 1'b0, 'h200, 0);
        cycle();
        check_eq("s33_g", {29'd0, obs_gnt}, 32'b010);
        rst = 1'b1;
        cycle();
        check_eq("s33_rv_squash", {29'd0, obs_rv}, 32'b000);
        rst = 1'b0;
        cycle();
        check_eq("s33_starve", obs_starve, 0);
        check_eq("s33_idle", {28'd0, obs_en, obs_gnt}, 32'd0);
        check_eq("s33_rv_idle", {29'd0, obs_rv}, 32'd0);

        // Randomized traffic with lock toggles and occasional reset.
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 3; p++) begin
                if (!req[p] && $urandom_range(0, 2) == 0)
                    set_req(p, (p != 2) && ($urandom_range(0, 2) == 0),
                            $urandom_range(0, 15), $urandom);
            end
            if ($urandom_range(0, 19) == 0) ld_lock = ~ld_lock;
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;
        ld_lock = 1'b0;
        drain();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter CELL_BITS, default 32, data word width.
REQ-002 Parameter ADDR_BITS, default 11, word address width (2048 words).
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive denied cycles before instruction fetch is promoted.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 For each port P in {ld (host loader), dt (CPU data FETCH/STORE), if (CPU instruction fetch)}, the following six signals SHALL exist.
- P_req  input  1  request.
- P_we  input  1  write enable; always 0 on the if port.
- P_addr  input  ADDR_BITS  word address.
- P_wdata  input  CELL_BITS  write data; unused on the if port.
- P_gnt  output  1  request accepted this cycle.
- P_rvalid  output  1  read data valid.
REQ-007 rdata  output  CELL_BITS  read data shared by all ports; qualified by P_rvalid.
REQ-008 ld_lock  input  1  while high, the loader owns memory exclusively.
REQ-009 mem_en, mem_we  output  1 each  single-port RAM enable and write strobe.
REQ-010 mem_addr  output  ADDR_BITS; mem_wdata  output  CELL_BITS  RAM address and write data.
REQ-011 mem_rdata  input  CELL_BITS  RAM read data, valid one cycle after a read with mem_en high.

Function
REQ-012 At most one P_gnt SHALL be high in any cycle.
REQ-013 P_gnt SHALL be combinational from the P_req inputs, ld_lock and registered state.
- A transfer occurs when P_req and P_gnt are both high.
- The requester SHALL hold addr, we and wdata stable while req is high and gnt is low.
REQ-014 Default priority: ld > dt > if.
REQ-015 Promotion rule:
- starve_cnt (registered) counts consecutive cycles with if_req=1 and if_gnt=0.
- When starve_cnt == STARVE_LIMIT and ld_lock=0, if SHALL win over ld and dt.
- starve_cnt SHALL clear on any if grant and in any cycle with if_req=0.
- starve_cnt SHALL saturate at STARVE_LIMIT.
REQ-016 While ld_lock=1:
- only ld may be granted;
- dt and if SHALL see gnt=0;
- starve_cnt SHALL hold its value.
REQ-017 The granted port's we/addr/wdata SHALL drive mem_we/mem_addr/mem_wdata in the same cycle, with mem_en=1.
REQ-018 With no grant, mem_en=0 and mem_we=0.
REQ-019 On a granted read, the owner SHALL be registered, and exactly one cycle later that port's P_rvalid=1 with rdata=mem_rdata.
REQ-020 A granted write SHALL produce no rvalid.
REQ-021 Back-to-back reads on consecutive cycles (same or different ports) SHALL each produce rvalid on the following cycle, with no bubble (throughput 1 access/cycle).
REQ-022 Read-after-write to the same address on consecutive cycles SHALL return the new data; the arbiter adds no forwarding and relies on RAM order.
REQ-023 When no rvalid is due, rdata SHALL equal mem_rdata and carries no meaning.

Reset
REQ-024 While rst=1:
- all P_gnt=0, mem_en=0, mem_we=0;
- starve_cnt <= 0 and the rvalid owner register <= none;
- all P_rvalid SHALL be 0 in the cycle after rst.
REQ-025 A read granted in the cycle before rst asserts SHALL NOT produce rvalid.

Structure
REQ-026 Package cpu_pkg SHALL hold:
- CELL_BITS and ADDR_BITS;
- the port-index enumeration {PORT_LD, PORT_DT, PORT_IF, PORT_NONE};
- STARVE_LIMIT's default.
REQ-027 One sub-module, mem_arb_pick, SHALL implement the combinational priority and promotion selection.
REQ-028 Counter and rvalid registers SHALL live in mem_arbiter.

Verification
REQ-029 All three ports read 0x010/0x020/0x030 simultaneously, held for 3 cycles -> grants ld, dt, if in consecutive cycles; each rvalid one cycle after its own grant, with matching data.
REQ-030 dt issues a continuous read stream while if_req is held high at 0x005, STARVE_LIMIT=4 -> if_gnt is first asserted on the 5th cycle, then dt resumes.
REQ-031 ld_lock=1 with ld writing 0xDEADBEEF to 0x7FF, while dt and if request -> only ld_gnt is high, starve_cnt is frozen; after release, a dt read of 0x7FF returns 0xDEADBEEF.
REQ-032 dt writes 0x12345678 to 0x040, then if reads 0x040 on the next cycle -> if_rvalid carries 0x12345678; no rvalid follows the write.
REQ-033 A dt read is granted, then rst is asserted the next cycle -> dt_rvalid stays 0; after rst, starve_cnt is 0 and all outputs are idle.
